// File: rtl/xmit_sched.sv
// Transmit frame scheduler: arbitrates hi/lo control FIFOs, length-checks, launches or discards, enforces IFG.
// Statistics counters are built only when XMIT_SCHED_STATS_EN is defined; otherwise the ports tie to zero.
module xmit_sched #(
  parameter int LEN_W        = 12,
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1536,
  parameter int MAX_HI_BURST = 8,
  parameter int IFG_CYCLES   = 48
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             hi_ctrl_valid,
  input  logic [LEN_W-1:0] hi_ctrl_len,
  output logic             hi_ctrl_pop,
  input  logic             lo_ctrl_valid,
  input  logic [LEN_W-1:0] lo_ctrl_len,
  output logic             lo_ctrl_pop,
  output logic             tx_start,
  output logic             tx_sel,
  output logic [LEN_W-1:0] tx_len,
  input  logic             tx_done,
  output logic             discard_en,
  output logic             sched_idle,
  output logic [15:0]      hi_tx_cnt,
  output logic [15:0]      lo_tx_cnt,
  output logic [15:0]      discard_cnt
);

  // state | meaning
  // IDLE  | arbitrate; latch winner when either queue is valid
  // POP   | one cycle: pop plus tx_start or discard_en
  // WAIT  | serializer busy until tx_done
  // IFG   | inter-frame gap down-counter
  typedef enum logic [1:0] {S_IDLE, S_POP, S_WAIT, S_IFG} state_t;

  localparam int BURST_W = (MAX_HI_BURST > 0) ? $clog2(MAX_HI_BURST + 1) : 1;
  localparam int IFG_W   = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_HI_BURST);
  localparam logic [IFG_W-1:0]   IFG_LOAD  = IFG_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [LEN_W-1:0]   LEN_MIN   = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0]   LEN_MAX   = LEN_W'(MAX_LEN);

  state_t             state;
  logic [BURST_W-1:0] burst;
  logic [IFG_W-1:0]   ifg_cnt;
  logic               burst_full;
  logic               pick_hi;
  logic [LEN_W-1:0]   win_len;
  logic               win_ok;

  always_comb begin
    burst_full = (MAX_HI_BURST != 0) && (burst == BURST_MAX);
    pick_hi    = hi_ctrl_valid && !(lo_ctrl_valid && burst_full);
    win_len    = pick_hi ? hi_ctrl_len : lo_ctrl_len;
    win_ok     = (win_len >= LEN_MIN) && (win_len <= LEN_MAX);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      burst       <= '0;
      ifg_cnt     <= '0;
      hi_ctrl_pop <= 1'b0;
      lo_ctrl_pop <= 1'b0;
      tx_start    <= 1'b0;
      discard_en  <= 1'b0;
      tx_sel      <= 1'b0;
      tx_len      <= '0;
      sched_idle  <= 1'b1;
    end else begin
      hi_ctrl_pop <= 1'b0;
      lo_ctrl_pop <= 1'b0;
      tx_start    <= 1'b0;
      discard_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hi_ctrl_valid || lo_ctrl_valid) begin
            tx_sel      <= pick_hi;
            tx_len      <= win_len;
            hi_ctrl_pop <= pick_hi;
            lo_ctrl_pop <= !pick_hi;
            tx_start    <= win_ok;
            discard_en  <= !win_ok;
            sched_idle  <= 1'b0;
            state       <= S_POP;
            // Burst only accumulates while lo is actually being held off.
            if (!pick_hi || !lo_ctrl_valid) begin
              burst <= '0;
            end else if (burst != BURST_MAX) begin
              burst <= burst + 1'b1;
            end
          end
        end
        S_POP: begin
          if (tx_start) begin
            state <= S_WAIT;
          end else begin
            state      <= S_IDLE;
            sched_idle <= 1'b1;
          end
        end
        S_WAIT: begin
          if (tx_done) begin
            if (IFG_CYCLES == 0) begin
              state      <= S_IDLE;
              sched_idle <= 1'b1;
            end else begin
              state   <= S_IFG;
              ifg_cnt <= IFG_LOAD;
            end
          end
        end
        S_IFG: begin
          if (ifg_cnt == '0) begin
            state      <= S_IDLE;
            sched_idle <= 1'b1;
          end else begin
            ifg_cnt <= ifg_cnt - 1'b1;
          end
        end
        default: begin
          state      <= S_IDLE;
          sched_idle <= 1'b1;
        end
      endcase
    end
  end

`ifdef XMIT_SCHED_STATS_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hi_tx_cnt   <= '0;
      lo_tx_cnt   <= '0;
      discard_cnt <= '0;
    end else begin
      if (tx_start && tx_sel && (hi_tx_cnt != 16'hFFFF)) begin
        hi_tx_cnt <= hi_tx_cnt + 16'd1;
      end
      if (tx_start && !tx_sel && (lo_tx_cnt != 16'hFFFF)) begin
        lo_tx_cnt <= lo_tx_cnt + 16'd1;
      end
      if (discard_en && (discard_cnt != 16'hFFFF)) begin
        discard_cnt <= discard_cnt + 16'd1;
      end
    end
  end
`else
  assign hi_tx_cnt   = '0;
  assign lo_tx_cnt   = '0;
  assign discard_cnt = '0;
`endif

endmodule

// File: tb/tb_xmit_sched.sv
// Bench for xmit_sched: two instances (default, and strict-priority with no gap) against a timeline model.
`timescale 1ns/1ps
module tb_xmit_sched;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        hi_ctrl_valid = 1'b0;
  logic        lo_ctrl_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic [11:0] hi_ctrl_len = '0;
  logic [11:0] lo_ctrl_len = '0;

  logic        hi_pop [2];
  logic        lo_pop [2];
  logic        tx_start [2];
  logic        tx_sel [2];
  logic [11:0] tx_len [2];
  logic        discard_en [2];
  logic        sched_idle [2];
  logic [15:0] hi_cnt [2];
  logic [15:0] lo_cnt [2];
  logic [15:0] dc_cnt [2];

  always #5 clk_sys = ~clk_sys;

  xmit_sched u_dut_a (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .hi_ctrl_valid(hi_ctrl_valid), .hi_ctrl_len(hi_ctrl_len), .hi_ctrl_pop(hi_pop[0]),
    .lo_ctrl_valid(lo_ctrl_valid), .lo_ctrl_len(lo_ctrl_len), .lo_ctrl_pop(lo_pop[0]),
    .tx_start(tx_start[0]), .tx_sel(tx_sel[0]), .tx_len(tx_len[0]), .tx_done(tx_done),
    .discard_en(discard_en[0]), .sched_idle(sched_idle[0]),
    .hi_tx_cnt(hi_cnt[0]), .lo_tx_cnt(lo_cnt[0]), .discard_cnt(dc_cnt[0])
  );

  xmit_sched #(.MAX_HI_BURST(0), .IFG_CYCLES(0)) u_dut_b (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .hi_ctrl_valid(hi_ctrl_valid), .hi_ctrl_len(hi_ctrl_len), .hi_ctrl_pop(hi_pop[1]),
    .lo_ctrl_valid(lo_ctrl_valid), .lo_ctrl_len(lo_ctrl_len), .lo_ctrl_pop(lo_pop[1]),
    .tx_start(tx_start[1]), .tx_sel(tx_sel[1]), .tx_len(tx_len[1]), .tx_done(tx_done),
    .discard_en(discard_en[1]), .sched_idle(sched_idle[1]),
    .hi_tx_cnt(hi_cnt[1]), .lo_tx_cnt(lo_cnt[1]), .discard_cnt(dc_cnt[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Timeline model: a frame occupies the scheduler until free_at, or until tx_done while awaiting.
  int   free_at [2];
  int   wait_from [2];
  int   hi_run [2];
  bit   awaiting [2];
  logic e_hp [2], e_lp [2], e_st [2], e_dc [2], e_sel [2], e_idle [2];
  logic [11:0] e_len [2];
  int   e_hc [2], e_lc [2], e_dcn [2];

  bit rec = 1'b0;
  bit seq_a [$];
  bit seq_b [$];

  function automatic int lim_of(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic int ifg_of(input int k);
    return (k == 0) ? 48 : 0;
  endfunction

  function automatic logic [11:0] pick_len();
    case ($urandom_range(0, 9))
      0: return 12'd0;
      1: return 12'd63;
      2: return 12'd64;
      3: return 12'd65;
      4: return 12'd1535;
      5: return 12'd1536;
      6: return 12'd1537;
      7: return 12'hFFF;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    free_at[k] = 0; wait_from[k] = 0; hi_run[k] = 0; awaiting[k] = 1'b0;
    e_hp[k] = 1'b0; e_lp[k] = 1'b0; e_st[k] = 1'b0; e_dc[k] = 1'b0;
    e_sel[k] = 1'b0; e_len[k] = '0; e_idle[k] = 1'b1;
    e_hc[k] = 0; e_lc[k] = 0; e_dcn[k] = 0;
  endtask

  task automatic model_step(input int k);
    int          lim;
    logic        g_hi;
    logic [11:0] l;
    lim = lim_of(k);
    if (e_st[k] && e_sel[k] && e_hc[k] < 65535) e_hc[k]++;
    if (e_st[k] && !e_sel[k] && e_lc[k] < 65535) e_lc[k]++;
    if (e_dc[k] && e_dcn[k] < 65535) e_dcn[k]++;
    e_hp[k] = 1'b0; e_lp[k] = 1'b0; e_st[k] = 1'b0; e_dc[k] = 1'b0;
    if (!awaiting[k] && cyc >= free_at[k] && (hi_ctrl_valid || lo_ctrl_valid)) begin
      g_hi = hi_ctrl_valid && !(lo_ctrl_valid && lim != 0 && hi_run[k] == lim);
      l = g_hi ? hi_ctrl_len : lo_ctrl_len;
      if (g_hi && lo_ctrl_valid) hi_run[k] = (hi_run[k] < lim) ? hi_run[k] + 1 : hi_run[k];
      else hi_run[k] = 0;
      e_sel[k] = g_hi; e_len[k] = l; e_hp[k] = g_hi; e_lp[k] = !g_hi;
      if (l >= 12'd64 && l <= 12'd1536) begin
        e_st[k] = 1'b1; awaiting[k] = 1'b1; wait_from[k] = cyc + 2;
      end else begin
        e_dc[k] = 1'b1; free_at[k] = cyc + 2;
      end
    end else if (awaiting[k] && cyc >= wait_from[k] && tx_done) begin
      awaiting[k] = 1'b0;
      free_at[k] = cyc + 1 + ifg_of(k);
    end
    e_idle[k] = !awaiting[k] && (cyc + 1) >= free_at[k];
  endtask

  task automatic check_outputs(input int k);
    string p;
    p = (k == 0) ? "a_" : "b_";
    chk({p, "pulses"}, 64'({hi_pop[k], lo_pop[k], tx_start[k], discard_en[k]}),
        64'({e_hp[k], e_lp[k], e_st[k], e_dc[k]}));
    chk({p, "tx_sel"}, 64'(tx_sel[k]), 64'(e_sel[k]));
    chk({p, "tx_len"}, 64'(tx_len[k]), 64'(e_len[k]));
    chk({p, "sched_idle"}, 64'(sched_idle[k]), 64'(e_idle[k]));
`ifdef XMIT_SCHED_STATS_EN
    chk({p, "stats"}, 64'({hi_cnt[k], lo_cnt[k], dc_cnt[k]}),
        64'({16'(e_hc[k]), 16'(e_lc[k]), 16'(e_dcn[k])}));
`else
    chk({p, "stats"}, 64'({hi_cnt[k], lo_cnt[k], dc_cnt[k]}), 64'd0);
`endif
    if (rec && (hi_pop[k] || lo_pop[k])) begin
      if (k == 0) seq_a.push_back(tx_sel[k]);
      else seq_b.push_back(tx_sel[k]);
    end
  endtask

  // Called at a falling edge: check this cycle, drive inputs, predict the next cycle.
  task automatic step(input logic hv, input logic lv, input logic [11:0] hl,
                      input logic [11:0] ll, input logic done);
    for (int k = 0; k < 2; k++) check_outputs(k);
    hi_ctrl_valid = hv; lo_ctrl_valid = lv;
    hi_ctrl_len = hl; lo_ctrl_len = ll; tx_done = done;
    for (int k = 0; k < 2; k++) model_step(k);
    cyc++;
    @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    for (int k = 0; k < 2; k++) check_outputs(k);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int done_cyc;
    for (int k = 0; k < 2; k++) model_reset(k);
    @(negedge clk_sys);
    reset_n = 1'b1;

    // Single hi frame, tx_done 64 cycles after start, stray tx_done in IDLE and mid-IFG.
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b1);
    step(1'b1, 1'b0, 12'h040, 12'h0, 1'b0);
    chk("p1_pop", 64'(hi_pop[0]), 64'd1);
    chk("p1_start", 64'(tx_start[0]), 64'd1);
    chk("p1_sel", 64'(tx_sel[0]), 64'd1);
    chk("p1_len", 64'(tx_len[0]), 64'h040);
    for (int i = 0; i < 63; i++) step(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    done_cyc = cyc;
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b1);
    chk("p1_b_idle", 64'(sched_idle[1]), 64'd1);
    n = 0;
    while (!sched_idle[0] && n < 100) begin
      step(1'b0, 1'b0, 12'h0, 12'h0, n == 20);
      n++;
    end
    chk("p1_ifg_gap", 64'(cyc - done_cyc - 1), 64'd48);

    // Short then long frame: both discarded, no gap.
    do_reset();
    step(1'b1, 1'b0, 12'h020, 12'h0, 1'b0);
    chk("p2_disc1", 64'({discard_en[0], tx_start[0], hi_pop[0]}), 64'b101);
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    step(1'b1, 1'b0, 12'h700, 12'h0, 1'b0);
    chk("p2_disc2", 64'({discard_en[0], tx_start[0], hi_pop[0]}), 64'b101);
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    chk("p2_no_ifg", 64'(sched_idle[0]), 64'd1);
`ifdef XMIT_SCHED_STATS_EN
    chk("p2_disc_cnt", 64'(dc_cnt[0]), 64'd2);
`else
    chk("p2_disc_cnt", 64'(dc_cnt[0]), 64'd0);
`endif

    // Both queues always valid: 8 hi then 1 lo on a; hi only on strict-priority b.
    do_reset();
    seq_a.delete(); seq_b.delete();
    rec = 1'b1;
    for (int i = 0; i < 1200 && seq_a.size() < 18; i++) step(1'b1, 1'b1, 12'h200, 12'h200, 1'b1);
    rec = 1'b0;
    chk("p3_a_count", 64'(seq_a.size()), 64'd18);
    foreach (seq_a[i]) chk("p3_a_order", 64'(seq_a[i]), 64'((i % 9) != 8));
    foreach (seq_b[i]) chk("p3_b_order", 64'(seq_b[i]), 64'd1);

    // Asynchronous reset during WAIT, then a fresh grant with a stale tx_done.
    do_reset();
    step(1'b1, 1'b0, 12'h100, 12'h0, 1'b0);
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    chk("p4_in_wait", 64'(sched_idle[0]), 64'd0);
    do_reset();
    chk("p4_len_clr", 64'(tx_len[0]), 64'd0);
    step(1'b1, 1'b0, 12'h080, 12'h0, 1'b1);
    chk("p4_regrant", 64'({hi_pop[0], tx_start[0]}), 64'b11);
    chk("p4_len", 64'(tx_len[0]), 64'h080);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 12'h0, 12'h0, 1'b0);
    chk("p4_still_wait", 64'(sched_idle[0]), 64'd0);
    step(1'b0, 1'b0, 12'h0, 12'h0, 1'b1);

    // No gap on b: back-to-back lo frames, next pop two cycles after tx_done.
    do_reset();
    n = 0;
    while (!lo_pop[1] && n < 10) begin
      step(1'b0, 1'b1, 12'h0, 12'h100, 1'b0);
      n++;
    end
    step(1'b0, 1'b1, 12'h0, 12'h100, 1'b0);
    done_cyc = cyc;
    step(1'b0, 1'b1, 12'h0, 12'h100, 1'b1);
    n = 0;
    while (!lo_pop[1] && n < 10) begin
      step(1'b0, 1'b1, 12'h0, 12'h100, 1'b0);
      n++;
    end
    chk("p5_gap", 64'(cyc - done_cyc), 64'd2);

    // Random traffic with boundary lengths and sporadic tx_done.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6, pick_len(), pick_len(),
           $urandom_range(0, 7) == 0);
    end
    for (int k = 0; k < 2; k++) check_outputs(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/xmit_sched.md
Name: xmit_sched

Overview:
- Frame-level scheduler for the transmit path. Arbitrates between the high- and low-priority control-block FIFOs.
- Checks each frame's length, then either launches the nibble serializer or commands a discard.
- Enforces an inter-frame gap between transmitted frames.
- Sits between the control FIFOs and the PHY serializer in the clk_sys domain.

Parameters:
- LEN_W, 12: width of the frame-length field (one 12-bit half of the 24-bit control block).
- MIN_LEN, 64: minimum legal frame length in bytes.
- MAX_LEN, 1536: maximum legal frame length in bytes.
- MAX_HI_BURST, 8: consecutive hi grants allowed while lo is pending; 0 = strict priority.
- IFG_CYCLES, 48: idle clk_sys cycles after tx_done (12 byte times at a 2:1 sys:phy ratio); 0 = no gap.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- hi_ctrl_valid  in  1  hi control FIFO non-empty.
- hi_ctrl_len  in  LEN_W  head-of-FIFO frame length, hi queue.
- hi_ctrl_pop  out  1  pop pulse, hi control FIFO.
- lo_ctrl_valid  in  1  lo control FIFO non-empty.
- lo_ctrl_len  in  LEN_W  head-of-FIFO frame length, lo queue.
- lo_ctrl_pop  out  1  pop pulse, lo control FIFO.
- tx_start  out  1  one-cycle start pulse to the serializer.
- tx_sel  out  1  queue being served (1 = hi); held stable from POP until return to IDLE.
- tx_len  out  LEN_W  latched length of the granted frame.
- tx_done  in  1  serializer end-of-frame pulse.
- discard_en  out  1  one-cycle pulse: drain the granted frame's data from its data FIFO.
- sched_idle  out  1  high in IDLE.
- hi_tx_cnt, lo_tx_cnt, discard_cnt  out  16 each  statistics counters (see Optional Feature).

Behaviour:
- Reset (async, reset_n low):
  - State = IDLE; burst counter = 0; IFG counter = 0.
  - All pulse outputs 0; tx_sel = 0; tx_len = 0; sched_idle = 1; counters = 0.
  - Reset mid-frame abandons the frame; any later tx_done is ignored.
- FSM states: IDLE, POP, WAIT, IFG.
- IDLE:
  - When hi_ctrl_valid | lo_ctrl_valid, compute the winner combinationally.
  - On the clock edge, latch tx_sel and tx_len from the winner and go to POP.
- Winner rule:
  - Hi wins if hi_ctrl_valid, unless lo_ctrl_valid and MAX_HI_BURST != 0 and burst == MAX_HI_BURST; lo wins in that case.
  - Lo wins if only lo is valid.
- Burst counter, updated at the IDLE decision:
  - +1 on a hi grant while lo_ctrl_valid.
  - Cleared on a lo grant, or on a hi grant with lo_ctrl_valid low.
  - Never exceeds MAX_HI_BURST.
- POP (exactly one cycle):
  - Assert the selected queue's pop.
  - If MIN_LEN <= tx_len <= MAX_LEN: assert tx_start and go to WAIT.
  - Otherwise: assert discard_en, go to IDLE, and skip the IFG.
  - Latency from valid seen in IDLE to tx_start/discard_en: 1 cycle.
- WAIT:
  - Hold until tx_done.
  - On tx_done, go to IFG (load counter = IFG_CYCLES-1), or to IDLE if IFG_CYCLES == 0.
  - tx_done in any state other than WAIT is ignored.
- IFG:
  - Decrement each cycle; go to IDLE when the counter reaches 0.
  - Exactly IFG_CYCLES cycles elapse between the tx_done cycle and re-entering IDLE.
- Only one pop per grant. Never both pops in the same cycle. tx_start and discard_en are mutually exclusive.
- Lengths are compared unsigned, full LEN_W width. A length of 0 is a discard.
- Queue valid dropping while in WAIT/IFG has no effect; the arbiter resamples only in IDLE.

Optional Feature:
- Macro: XMIT_SCHED_STATS_EN.
- Defined:
  - hi_tx_cnt / lo_tx_cnt increment on tx_start per tx_sel.
  - discard_cnt increments on discard_en.
  - All three saturate at 16'hFFFF and clear only on reset.
- Undefined: the three ports are driven constant 0 and no counter flops are synthesized.

Test Plan:
- Only hi valid, len 0x040, tx_done 64 cycles later:
  - hi_ctrl_pop and tx_start on the cycle after IDLE, tx_sel = 1, tx_len = 0x040.
  - sched_idle returns exactly 48 cycles after tx_done.
- Both queues always valid, len 0x200, MAX_HI_BURST = 8:
  - Grant sequence is 8 hi then 1 lo, repeating.
  - With MAX_HI_BURST = 0, lo is never granted.
- hi len 0x020 (below MIN) then hi len 0x700 (above MAX):
  - Two discard_en pulses with pops, no tx_start, no IFG.
  - discard_cnt = 2 with the macro, 0 without.
- tx_done pulsed in IDLE and IFG:
  - No state change, no extra pops.
  - The IFG length stays exactly 48 cycles.
- reset_n asserted asynchronously mid-WAIT:
  - All outputs at reset values immediately.
  - After release with hi valid, a fresh grant occurs; a stale tx_done is ignored.
- IFG_CYCLES = 0, lo only, back-to-back frames:
  - The next pop occurs 2 cycles after tx_done (IDLE, then POP).
